// File: rtl/mem_arb.sv
// Two-requester arbiter (instruction fetch, load/store) in front of a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin contention; the default build gives load/store fixed priority.
module mem_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req,
    input  logic [7:0] if_addr,
    output logic       if_gnt,
    output logic       if_rvalid,
    output logic [7:0] if_rdata,
    input  logic       ls_req,
    input  logic       ls_wr,
    input  logic [7:0] ls_addr,
    input  logic [7:0] ls_wdata,
    output logic       ls_gnt,
    output logic       ls_rvalid,
    output logic [7:0] ls_rdata,
    output logic       mem_enable,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0] starve_q, starve_d;
    logic       if_own_q, if_own_d;
    logic       ls_own_q, ls_own_d;
    logic       if_win, ls_win;

`ifdef MEM_ARB_RR_EN
    // rr_q=1 means load/store is favoured on the next contested cycle
    logic       rr_q, rr_d;
`endif

    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (!rst) begin
            if (if_req && (starve_q == STARVE_LIM)) begin
                if_win = 1'b1;
            end else if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
                if (rr_q) ls_win = 1'b1;
                else      if_win = 1'b1;
`else
                ls_win = 1'b1;
`endif
            end else if (if_req) begin
                if_win = 1'b1;
            end else if (ls_req) begin
                ls_win = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_win) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 3'd1;
        end
        if_own_d = if_win;
        ls_own_d = ls_win && !ls_wr;
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        rr_d = rr_q;
        if (if_req && ls_req && (if_win || ls_win)) begin
            rr_d = if_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            if_own_q <= 1'b0;
            ls_own_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            if_own_q <= if_own_d;
            ls_own_q <= ls_own_d;
        end
    end

    always_comb begin
        if_gnt      = if_win;
        ls_gnt      = ls_win;
        mem_enable  = if_win || ls_win;
        mem_wr      = ls_win && ls_wr;
        mem_addr    = ls_win ? ls_addr : (if_win ? if_addr : '0);
        mem_data_in = ls_win ? ls_wdata : '0;
        if_rvalid   = if_own_q;
        ls_rvalid   = ls_own_q;
        if_rdata    = if_own_q ? mem_data_out : '0;
        ls_rdata    = ls_own_q ? mem_data_out : '0;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural synchronous memory; contention expectations
// follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_req, ls_req, ls_wr;
    logic [7:0] if_addr, ls_addr, ls_wdata;
    logic       if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [7:0] if_rdata, ls_rdata;
    logic       mem_enable, mem_wr;
    logic [7:0] mem_addr, mem_data_in, mem_data_out;

    logic [7:0] mem [256];
    logic [7:0] mem_rd = '0;
    logic       preload;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arb #(.STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .ls_req       (ls_req),
        .ls_wr        (ls_wr),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_gnt       (ls_gnt),
        .ls_rvalid    (ls_rvalid),
        .ls_rdata     (ls_rdata),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= 8'hA5;
            mem[8'h01] <= 8'h11;
            mem[8'h02] <= 8'h22;
            mem[8'h30] <= 8'h5A;
            mem[8'h31] <= 8'hC3;
        end else if (mem_enable) begin
            if (mem_wr) mem[mem_addr] <= mem_data_in;
            else        mem_rd <= mem[mem_addr];
        end
    end
    assign mem_data_out = mem_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] exp_if;

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_if = 6'b010101;
`else
        exp_if = 6'b010000;
`endif
        rst = 1'b1; preload = 1'b1;
        if_req = 1'b1; if_addr = 8'h10;
        ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_wdata = '0;
        tick;
        tick;
        check("rst_if_gnt", 32'(if_gnt), 0);
        check("rst_ls_gnt", 32'(ls_gnt), 0);
        check("rst_mem_en", 32'(mem_enable), 0);
        check("rst_if_rvalid", 32'(if_rvalid), 0);

        // single fetch read, in the first cycle after reset release
        preload = 1'b0; rst = 1'b0;
        #1;
        check("rd_if_gnt", 32'(if_gnt), 1);
        check("rd_mem_addr", 32'(mem_addr), 32'h10);
        check("rd_mem_wr", 32'(mem_wr), 0);
        check("rd_ls_gnt", 32'(ls_gnt), 0);
        tick;
        if_req = 1'b0;
        #1;
        check("rd_if_rvalid", 32'(if_rvalid), 1);
        check("rd_if_rdata", 32'(if_rdata), 32'hA5);
        check("rd_ls_rvalid", 32'(ls_rvalid), 0);
        check("idle_mem_en", 32'(mem_enable), 0);
        check("idle_mem_addr", 32'(mem_addr), 0);
        tick;
        check("idle_if_rvalid", 32'(if_rvalid), 0);
        check("idle_if_rdata", 32'(if_rdata), 0);

        // store then load back
        ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 8'h20; ls_wdata = 8'h3C;
        #1;
        check("st_ls_gnt", 32'(ls_gnt), 1);
        check("st_mem_wr", 32'(mem_wr), 1);
        check("st_mem_din", 32'(mem_data_in), 32'h3C);
        check("st_mem_addr", 32'(mem_addr), 32'h20);
        tick;
        ls_wr = 1'b0;
        #1;
        check("st_ls_rvalid", 32'(ls_rvalid), 0);
        check("ld_ls_gnt", 32'(ls_gnt), 1);
        check("ld_mem_wr", 32'(mem_wr), 0);
        tick;
        ls_req = 1'b0;
        #1;
        check("ld_ls_rvalid", 32'(ls_rvalid), 1);
        check("ld_ls_rdata", 32'(ls_rdata), 32'h3C);
        check("ld_if_rvalid", 32'(if_rvalid), 0);
        tick;

        // pipelined IF then LS reads
        if_req = 1'b1; if_addr = 8'h01;
        #1;
        check("pp_if_gnt", 32'(if_gnt), 1);
        tick;
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 8'h02;
        #1;
        check("pp_ls_gnt", 32'(ls_gnt), 1);
        check("pp_if_rvalid", 32'(if_rvalid), 1);
        check("pp_if_rdata", 32'(if_rdata), 32'h11);
        tick;
        ls_req = 1'b0;
        #1;
        check("pp_ls_rvalid", 32'(ls_rvalid), 1);
        check("pp_ls_rdata", 32'(ls_rdata), 32'h22);
        check("pp_if_rvalid_off", 32'(if_rvalid), 0);

        // contention for six cycles, back-to-back grants
        if_req = 1'b1; if_addr = 8'h30; ls_req = 1'b1; ls_addr = 8'h31;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("ct%0d_if_gnt", i), 32'(if_gnt), 32'(exp_if[i]));
            check($sformatf("ct%0d_ls_gnt", i), 32'(ls_gnt), 32'(!exp_if[i]));
            if (i > 0) begin
                check($sformatf("ct%0d_if_rvalid", i), 32'(if_rvalid), 32'(exp_if[i-1]));
                check($sformatf("ct%0d_ls_rvalid", i), 32'(ls_rvalid), 32'(!exp_if[i-1]));
                if (exp_if[i-1]) check($sformatf("ct%0d_if_rdata", i), 32'(if_rdata), 32'h5A);
                else             check($sformatf("ct%0d_ls_rdata", i), 32'(ls_rdata), 32'hC3);
            end
            tick;
        end
        if_req = 1'b0; ls_req = 1'b0;
        #1;
        check("ct_last_ls_rvalid", 32'(ls_rvalid), 1);
        check("ct_last_ls_rdata", 32'(ls_rdata), 32'hC3);
        tick;

        // reset while a fetch read is in flight
        if_req = 1'b1; if_addr = 8'h10;
        #1;
        check("mr_if_gnt", 32'(if_gnt), 1);
        tick;
        rst = 1'b1;
        #1;
        check("mr_if_rvalid", 32'(if_rvalid), 0);
        check("mr_if_rdata", 32'(if_rdata), 0);
        check("mr_if_gnt_rst", 32'(if_gnt), 0);
        check("mr_mem_en", 32'(mem_enable), 0);
        check("mr_mem_addr", 32'(mem_addr), 0);
        tick;
        check("mr_if_rvalid2", 32'(if_rvalid), 0);
        check("mr_ls_rvalid2", 32'(ls_rvalid), 0);
        if_req = 1'b0; rst = 1'b0;
        tick;
        check("mr_post_if_rvalid", 32'(if_rvalid), 0);
        check("mr_post_ls_rvalid", 32'(ls_rvalid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
